// File: rtl/alu_result_collector.sv
// alu_result_collector
//   Pairs each ALU result with the oldest in-flight issue tag. Register writes
//   are buffered and retired through a valid/ready writeback port. Branch
//   outcomes are sent to the PC logic as a one-cycle pulse.
//   Optional build macro: ALU_COLLECTOR_OVF_TRAP_EN adds ovf_trap/ovf_rd.
//
// Handshake semantics (both ports):
//   issue: an op is accepted on a rising edge where issue_valid && issue_ready.
//          issue_ready depends only on the current occupancy, so it never
//          depends on issue_valid.
//   wb:    an entry retires on a rising edge where wb_valid && wb_ready.
//          While wb_valid=1, wb_rd/wb_data stay stable until that edge.
//          wb_valid never depends on wb_ready.
module alu_result_collector #(
  parameter int DEPTH = 4
) (
  input  logic                     soc_clk,
  input  logic                     reset,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic [1:0]               issue_kind,
  input  logic [4:0]               issue_rd,
  input  logic [31:0]              issue_target,
  input  logic [31:0]              ALU_out,
  input  logic                     ALU_ready,
  input  logic                     ALU_con_met,
  input  logic                     ALU_overflow,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [4:0]               wb_rd,
  output logic [31:0]              wb_data,
  output logic                     br_valid,
  output logic                     br_taken,
  output logic [31:0]              br_target,
  output logic                     err_orphan,
  output logic [$clog2(DEPTH):0]   occupancy
`ifdef ALU_COLLECTOR_OVF_TRAP_EN
  ,
  output logic                     ovf_trap,
  output logic [4:0]               ovf_rd
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    KIND_REG     = 2'd0,
    KIND_BRANCH  = 2'd1,
    KIND_DISCARD = 2'd2,
    KIND_RSVD    = 2'd3
  } kind_e;

  // Tag queue storage
  logic [1:0]    tag_kind_mem [DEPTH];
  logic [4:0]    tag_rd_mem   [DEPTH];
  logic [31:0]   tag_tgt_mem  [DEPTH];
  logic [PW-1:0] tag_wr_ptr;
  logic [PW-1:0] tag_rd_ptr;
  logic [CW-1:0] tag_cnt;

  // Result queue storage
  logic [4:0]    res_rd_mem   [DEPTH];
  logic [31:0]   res_data_mem [DEPTH];
  logic [PW-1:0] res_wr_ptr;
  logic [PW-1:0] res_rd_ptr;
  logic [CW-1:0] res_cnt;

  logic          issue_push;
  logic          tag_pop;
  logic          res_push;
  logic          wb_pop;
  kind_e         head_kind;
  logic [4:0]    head_rd;
  logic [31:0]   head_tgt;

  // Handshake decode, tag-head lookup and writeback presentation.
  // Occupancy always reserves a result slot for every outstanding tag, so
  // ALU_ready never needs back-pressure.
  always_comb begin
    occupancy   = tag_cnt + res_cnt;
    issue_ready = (occupancy < CW'(DEPTH));
    issue_push  = issue_valid && issue_ready;
    head_kind   = kind_e'(tag_kind_mem[tag_rd_ptr]);
    head_rd     = tag_rd_mem[tag_rd_ptr];
    head_tgt    = tag_tgt_mem[tag_rd_ptr];
    tag_pop     = ALU_ready && (tag_cnt != '0);
    res_push    = tag_pop && (head_kind == KIND_REG) && (head_rd != 5'd0);
    wb_valid    = (res_cnt != '0);
    wb_pop      = wb_valid && wb_ready;
    wb_rd       = wb_valid ? res_rd_mem[res_rd_ptr]   : 5'd0;
    wb_data     = wb_valid ? res_data_mem[res_rd_ptr] : 32'd0;
  end

  // Queue payload writes; contents are only read under a non-zero count.
  always_ff @(posedge soc_clk) begin
    if (issue_push) begin
      tag_kind_mem[tag_wr_ptr] <= issue_kind;
      tag_rd_mem[tag_wr_ptr]   <= issue_rd;
      tag_tgt_mem[tag_wr_ptr]  <= issue_target;
    end
    if (res_push) begin
      res_rd_mem[res_wr_ptr]   <= head_rd;
      res_data_mem[res_wr_ptr] <= ALU_out;
    end
  end

  // Pointers and counts for both queues; pointers wrap modulo DEPTH.
  always_ff @(posedge soc_clk or posedge reset) begin
    if (reset) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      tag_cnt    <= '0;
      res_wr_ptr <= '0;
      res_rd_ptr <= '0;
      res_cnt    <= '0;
    end else begin
      if (issue_push) tag_wr_ptr <= tag_wr_ptr + 1'b1;
      if (tag_pop)    tag_rd_ptr <= tag_rd_ptr + 1'b1;
      if (res_push)   res_wr_ptr <= res_wr_ptr + 1'b1;
      if (wb_pop)     res_rd_ptr <= res_rd_ptr + 1'b1;
      tag_cnt <= tag_cnt + CW'(issue_push) - CW'(tag_pop);
      res_cnt <= res_cnt + CW'(res_push) - CW'(wb_pop);
    end
  end

  // Branch resolution pulse and the sticky orphan-result flag.
  always_ff @(posedge soc_clk or posedge reset) begin
    if (reset) begin
      br_valid   <= 1'b0;
      br_taken   <= 1'b0;
      br_target  <= 32'd0;
      err_orphan <= 1'b0;
    end else begin
      br_valid <= tag_pop && (head_kind == KIND_BRANCH);
      if (tag_pop && (head_kind == KIND_BRANCH)) begin
        br_taken  <= ALU_con_met;
        br_target <= head_tgt;
      end
      if (ALU_ready && (tag_cnt == '0)) err_orphan <= 1'b1;
    end
  end

`ifdef ALU_COLLECTOR_OVF_TRAP_EN
  // Overflow trap pulse for register-write ops; the result still retires.
  always_ff @(posedge soc_clk or posedge reset) begin
    if (reset) begin
      ovf_trap <= 1'b0;
      ovf_rd   <= 5'd0;
    end else begin
      ovf_trap <= tag_pop && (head_kind == KIND_REG) && ALU_overflow;
      if (tag_pop && (head_kind == KIND_REG) && ALU_overflow) ovf_rd <= head_rd;
    end
  end
`else
  logic unused_ovf;
  assign unused_ovf = ALU_overflow;
`endif

endmodule

// File: tb/tb_alu_result_collector.sv
// tb_alu_result_collector
//   Scoreboard bench: expected writebacks and branch outcomes are queued when
//   the ALU result is driven and compared when the collector presents them.
module tb_alu_result_collector;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic soc_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 soc_clk = ~soc_clk;

  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [1:0]  issue_kind = 2'd0;
  logic [4:0]  issue_rd = 5'd0;
  logic [31:0] issue_target = 32'd0;
  logic [31:0] ALU_out = 32'd0;
  logic        ALU_ready = 1'b0;
  logic        ALU_con_met = 1'b0;
  logic        ALU_overflow = 1'b0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        br_valid;
  logic        br_taken;
  logic [31:0] br_target;
  logic        err_orphan;
  logic [$clog2(DEPTH):0] occupancy;
`ifdef ALU_COLLECTOR_OVF_TRAP_EN
  logic        ovf_trap;
  logic [4:0]  ovf_rd;
`endif

  alu_result_collector #(.DEPTH(DEPTH)) dut (
    .soc_clk      (soc_clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_kind   (issue_kind),
    .issue_rd     (issue_rd),
    .issue_target (issue_target),
    .ALU_out      (ALU_out),
    .ALU_ready    (ALU_ready),
    .ALU_con_met  (ALU_con_met),
    .ALU_overflow (ALU_overflow),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .br_valid     (br_valid),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .err_orphan   (err_orphan),
    .occupancy    (occupancy)
`ifdef ALU_COLLECTOR_OVF_TRAP_EN
    ,
    .ovf_trap     (ovf_trap),
    .ovf_rd       (ovf_rd)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [38:0] tag_q[$];   // {kind, rd, target} of ops issued, not yet resolved
  logic [36:0] exp_q[$];   // {rd, data} expected on writeback
  logic [32:0] br_q[$];    // {taken, target} expected on branch pulse
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One clock of stimulus, entered and left at posedge+1.
  task automatic cycle(input bit di, input logic [1:0] k, input logic [4:0] rd,
                       input logic [31:0] tgt, input bit da, input logic [31:0] d,
                       input bit con);
    int occ;
    bit accept;
    logic [38:0] t;
    occ    = tag_q.size() + exp_q.size();
    accept = (occ < DEPTH);
    check_eq("occupancy", 64'(occupancy), 64'(occ));
    check_eq("issue_ready", 64'(issue_ready), 64'(accept));
    issue_valid  = di;
    issue_kind   = k;
    issue_rd     = rd;
    issue_target = tgt;
    ALU_ready    = da;
    ALU_out      = d;
    ALU_con_met  = con;
    if (da && tag_q.size() > 0) begin
      t = tag_q.pop_front();
      if (t[38:37] == 2'd0 && t[36:32] != 5'd0) exp_q.push_back({t[36:32], d});
      else if (t[38:37] == 2'd1) br_q.push_back({con, t[31:0]});
    end
    if (di && accept) tag_q.push_back({k, rd, tgt});
    @(posedge soc_clk);
    #1;
    issue_valid = 1'b0;
    ALU_ready   = 1'b0;
  endtask

  task automatic idle();
    cycle(1'b0, 2'd0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge soc_clk) begin
    if (!reset) begin
      if (wb_valid) begin
        if (exp_q.size() == 0) check_eq("wb_unexpected", 64'd1, 64'd0);
        else begin
          check_eq("wb_head", 64'({wb_rd, wb_data}), 64'(exp_q[0]));
          if (wb_ready) void'(exp_q.pop_front());
        end
      end
      if (br_valid) begin
        if (br_q.size() == 0) check_eq("br_unexpected", 64'd1, 64'd0);
        else check_eq("br_entry", 64'({br_taken, br_target}), 64'(br_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // reset state (reset held from time 0)
    @(posedge soc_clk);
    #1;
    check_eq("rst_issue_ready", 64'(issue_ready), 64'd1);
    check_eq("rst_occupancy", 64'(occupancy), 64'd0);
    check_eq("rst_wb", 64'({wb_valid, wb_rd, wb_data}), 64'd0);
    check_eq("rst_br", 64'({br_valid, br_taken, br_target}), 64'd0);
    check_eq("rst_orphan", 64'(err_orphan), 64'd0);
    @(posedge soc_clk);
    #1;
    reset = 1'b0;

    // T1: single register write
    wb_ready = 1'b1;
    cycle(1'b1, 2'd0, 5'd5, 32'd0, 1'b0, 32'd0, 1'b0);
    check_eq("t1_occ_issued", 64'(occupancy), 64'd1);
    cycle(1'b0, 2'd0, 5'd0, 32'd0, 1'b1, 32'h0000_002A, 1'b0);
    check_eq("t1_wb", 64'({wb_valid, wb_rd, wb_data}), 64'({1'b1, 5'd5, 32'h2A}));
    idle();
    check_eq("t1_occ_done", 64'(occupancy), 64'd0);

    // T2: taken branch
    cycle(1'b1, 2'd1, 5'd0, 32'h0000_0100, 1'b0, 32'd0, 1'b0);
    cycle(1'b0, 2'd0, 5'd0, 32'd0, 1'b1, 32'h1234, 1'b1);
    check_eq("t2_br", 64'({br_valid, br_taken, br_target}), 64'({1'b1, 1'b1, 32'h100}));
    check_eq("t2_no_wb", 64'(wb_valid), 64'd0);
    idle();
    check_eq("t2_br_pulse_end", 64'(br_valid), 64'd0);
    check_eq("t2_occ", 64'(occupancy), 64'd0);

    // T3: fill to DEPTH with writeback stalled, then drain in order
    wb_ready = 1'b0;
    for (int i = 1; i <= 4; i++) cycle(1'b1, 2'd0, 5'(i), 32'd0, 1'b0, 32'd0, 1'b0);
    check_eq("t3_full_ready", 64'(issue_ready), 64'd0);
    cycle(1'b1, 2'd0, 5'd9, 32'd0, 1'b0, 32'd0, 1'b0);  // ignored while full
    check_eq("t3_full_occ", 64'(occupancy), 64'd4);
    for (int i = 1; i <= 4; i++) cycle(1'b0, 2'd0, 5'd0, 32'd0, 1'b1, 32'(i * 'h11), 1'b0);
    check_eq("t3_stall_head", 64'({wb_valid, wb_rd, wb_data}), 64'({1'b1, 5'd1, 32'h11}));
    wb_ready = 1'b1;
    idle();
    check_eq("t3_ready_after_pop", 64'(issue_ready), 64'd1);
    for (int i = 0; i < 3; i++) idle();
    check_eq("t3_drained", 64'(occupancy), 64'd0);

    // T4: write to x0 is dropped
    cycle(1'b1, 2'd0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    check_eq("t4_occ1", 64'(occupancy), 64'd1);
    cycle(1'b0, 2'd0, 5'd0, 32'd0, 1'b1, 32'h77, 1'b0);
    check_eq("t4_no_wb", 64'(wb_valid), 64'd0);
    check_eq("t4_occ0", 64'(occupancy), 64'd0);

    // Random mix of simultaneous issue / result / writeback events
    for (int i = 0; i < 150; i++) begin
      wb_ready     = ($urandom_range(0, 3) != 0);
      ALU_overflow = 1'($urandom_range(0, 1));
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
            $urandom, (tag_q.size() > 0) && ($urandom_range(0, 1) == 1), $urandom,
            1'($urandom_range(0, 1)));
    end
    wb_ready = 1'b1;
    ALU_overflow = 1'b0;
    for (int i = 0; i < 2 * DEPTH && tag_q.size() > 0; i++)
      cycle(1'b0, 2'd0, 5'd0, 32'd0, 1'b1, $urandom, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 2 * DEPTH; i++) idle();
    check_eq("rand_drained", 64'(occupancy), 64'd0);
    check_eq("rand_orphan_clear", 64'(err_orphan), 64'd0);

    // T5: orphan result
    cycle(1'b0, 2'd0, 5'd0, 32'd0, 1'b1, 32'h55, 1'b0);
    check_eq("t5_orphan", 64'(err_orphan), 64'd1);
    check_eq("t5_no_wb", 64'(wb_valid), 64'd0);
    for (int i = 0; i < 3; i++) idle();
    check_eq("t5_orphan_sticky", 64'(err_orphan), 64'd1);

    // T6: asynchronous reset with 2 tags and 1 result held
    wb_ready = 1'b0;
    cycle(1'b1, 2'd0, 5'd3, 32'd0, 1'b0, 32'd0, 1'b0);
    cycle(1'b1, 2'd0, 5'd4, 32'd0, 1'b0, 32'd0, 1'b0);
    cycle(1'b1, 2'd1, 5'd0, 32'h200, 1'b1, 32'hAB, 1'b1);
    check_eq("t6_occ_before", 64'(occupancy), 64'd3);
    #2;
    reset = 1'b1;
    tag_q.delete();
    exp_q.delete();
    br_q.delete();
    #1;
    check_eq("t6_rst_occ", 64'(occupancy), 64'd0);
    check_eq("t6_rst_ready", 64'(issue_ready), 64'd1);
    check_eq("t6_rst_wb", 64'({wb_valid, wb_rd, wb_data}), 64'd0);
    check_eq("t6_rst_br", 64'({br_valid, br_taken, br_target}), 64'd0);
    check_eq("t6_rst_orphan", 64'(err_orphan), 64'd0);
    @(posedge soc_clk);
    @(posedge soc_clk);
    #1;
    reset = 1'b0;
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) idle();
    check_eq("t6_post_wb", 64'(wb_valid), 64'd0);
    check_eq("t6_post_br", 64'(br_valid), 64'd0);

    // ---------------- final report ----------------
    check_eq("exp_q_empty", 64'(exp_q.size()), 64'd0);
    check_eq("br_q_empty", 64'(br_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_collector.md
Name: alu_result_collector

Overview:
- Sits directly downstream of the ALU.
- Holds a tag queue of in-flight ALU operations issued by the CU: destination register, kind and branch target.
- On each one-cycle ALU_ready pulse, pairs the ALU result with the oldest tag. Register writes are retired through a buffered valid/ready writeback port to the register file; branch decisions go to the PC logic as a one-cycle pulse.

Parameters:
- DEPTH, 4, maximum outstanding entries (tags plus buffered results); power of two, >= 2.

Ports:
- soc_clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous active-high reset
- issue_valid  in  1  CU issues one op to the ALU this cycle
- issue_ready  out  1  collector can accept an issue
- issue_kind  in  2  0=reg write, 1=branch, 2=discard, 3=reserved (treated as discard)
- issue_rd  in  5  destination register
- issue_target  in  32  branch target address
- ALU_out  in  32  ALU result
- ALU_ready  in  1  one-cycle result-valid pulse
- ALU_con_met  in  1  branch/compare condition
- ALU_overflow  in  1  add/sub overflow
- wb_valid  out  1  writeback entry available
- wb_ready  in  1  register file accepts entry
- wb_rd  out  5  writeback register
- wb_data  out  32  writeback data
- br_valid  out  1  one-cycle branch-resolved pulse
- br_taken  out  1  branch outcome
- br_target  out  32  branch target
- err_orphan  out  1  sticky: ALU_ready arrived with the tag queue empty
- occupancy  out  $clog2(DEPTH)+1  tags plus results held

Behaviour:
- Reset (asynchronous, active-high) clears:
  - both queues and all pointers;
  - occupancy=0, wb_valid=0, wb_rd=0, wb_data=0;
  - br_valid=0, br_taken=0, br_target=0, err_orphan=0.
- issue_ready is combinational: occupancy < DEPTH. It is 1 during and after reset.
- Issue push happens when issue_valid && issue_ready. issue_valid while issue_ready=0 is ignored; no state changes.
- Occupancy guarantees result-queue space, so ALU_ready is never back-pressured.
- On ALU_ready with the tag queue non-empty, pop the head tag in the same cycle, then act on its kind:
  - kind 0, rd != 0: push {rd, ALU_out} into the result queue.
  - kind 0, rd == 0: drop the result; occupancy -1.
  - kind 1: next cycle br_valid=1, br_taken=registered ALU_con_met, br_target=the tag's target; occupancy -1. br_valid is 0 in every other cycle.
  - kind 2/3: drop; occupancy -1.
- On ALU_ready with the tag queue empty: set err_orphan=1 (cleared only by reset); nothing else changes.
- Latency:
  - A result pushed at edge N is presented on wb_valid/wb_rd/wb_data after edge N.
  - An issue pushed at edge N can be popped by an ALU_ready sampled at edge N+1 or later.
- Writeback:
  - wb_* present the result-queue head.
  - A pop happens on wb_valid && wb_ready; occupancy -1.
  - wb_rd/wb_data must hold stable while wb_valid=1 and wb_ready=0.
- Simultaneous events are all applied in the same cycle:
  - issue push + tag pop + result push + wb pop.
  - Net occupancy = +issue − (dropped/branch pop) − wb pop.
  - Issue into a tag queue that is being popped is legal even when the queue is full only because of the same-cycle pop? No: issue_ready uses current occupancy only, with no same-cycle credit.
- Pointers wrap modulo DEPTH. Order is strictly FIFO in both queues.
- ALU_overflow is ignored unless the optional feature is enabled.

Optional Feature:
- Macro ALU_COLLECTOR_OVF_TRAP_EN.
- Defined:
  - adds output ovf_trap (1) and ovf_rd (5);
  - ovf_trap pulses one cycle after a kind-0 pop with ALU_overflow=1, with ovf_rd=the tag's rd;
  - the result is still written back normally;
  - both outputs reset to 0.
- Undefined: the ports are absent and ALU_overflow is unused.

Test Plan:
- Reset, then issue kind0 rd=5, then ALU_ready with ALU_out=0x0000_002A, wb_ready=1
  -> wb_valid=1, wb_rd=5, wb_data=0x2A one cycle after the pulse; occupancy returns to 0.
- Issue kind1 target=0x0000_0100, then ALU_ready with ALU_con_met=1
  -> br_valid pulses exactly one cycle, br_taken=1, br_target=0x100; wb_valid stays 0.
- wb_ready=0; issue 4 kind0 ops (rd=1..4); return ALU results 0x11..0x44
  -> issue_ready=0 at occupancy 4; draining with wb_ready=1 yields rd1..4, data 0x11..0x44 in order; issue_ready re-asserts after the first pop.
- Issue kind0 rd=0, then ALU_ready
  -> no wb_valid; occupancy 1 -> 0.
- ALU_ready with no issue outstanding
  -> err_orphan=1 and stays set until reset; queues unchanged.
- Assert reset asynchronously mid-stream (2 tags plus 1 result held)
  -> all outputs 0 immediately, occupancy=0, issue_ready=1, no spurious br_valid/wb_valid after release.
